// File: rtl/pixel_frame_buffer_if.sv
// Producer/VGA-side bundle of the double-buffered pixel store: write stream,
// front-bank read port, Vsync input and bank status.
interface pixel_frame_buffer_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 9
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              Vsync;
    logic              front_sel;
    logic              swap_done;

    modport master (
        output wr_valid, wr_data, wr_last, rd_addr, Vsync,
        input  wr_ready, rd_data, front_sel, swap_done
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_addr, Vsync,
        output wr_ready, rd_data, front_sel, swap_done
    );
endinterface

// File: rtl/pixel_frame_buffer.sv
// Double-buffered RGB333 frame store: producer fills the back bank, VGA reads the
// front bank, and banks swap on the Vsync falling edge once a frame is complete.
module pixel_frame_buffer #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 9,
    parameter int DEPTH  = 6144
) (
    input logic                  clk25,
    input logic                  rst,
    pixel_frame_buffer_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {FILL, WAIT_SWAP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic              front_sel_q, front_sel_nxt;
    logic              swap_q, swap_nxt;
    logic              vs_d;
    logic              wr_accept;
    logic              vs_fall;
    logic [DATA_W-1:0] rd_data_p1;

    logic [DATA_W-1:0] mem [2][DEPTH];

    function automatic logic in_frame(input logic [ADDR_W-1:0] a);
        return a <= LAST_ADDR;
    endfunction

    assign bus.wr_ready  = (state == FILL) && !rst;
    assign wr_accept     = bus.wr_valid && bus.wr_ready;
    assign vs_fall       = vs_d && !bus.Vsync;
    assign bus.front_sel = front_sel_q;
    assign bus.swap_done = swap_q;
    assign bus.rd_data   = rd_data_p1;

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        front_sel_nxt = front_sel_q;
        swap_nxt      = 1'b0;
        case (state)
            FILL: begin
                // A Vsync edge arriving here is deliberately dropped; the swap needs a later edge.
                if (wr_accept) begin
                    if (bus.wr_last || wr_ptr == LAST_ADDR) begin
                        state_nxt = WAIT_SWAP;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 1'b1;
                    end
                end
            end
            WAIT_SWAP: begin
                if (vs_fall) begin
                    front_sel_nxt = ~front_sel_q;
                    swap_nxt      = 1'b1;
                    wr_ptr_nxt    = '0;
                    state_nxt     = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state       <= FILL;
            wr_ptr      <= '0;
            front_sel_q <= 1'b0;
            swap_q      <= 1'b0;
            vs_d        <= 1'b1;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            front_sel_q <= front_sel_nxt;
            swap_q      <= swap_nxt;
            vs_d        <= bus.Vsync;
        end
    end

    always_ff @(posedge clk25) begin
        if (wr_accept) begin
            mem[~front_sel_q][wr_ptr] <= bus.wr_data;
        end
    end

    // Read stage p1: bank and address sampled together, so a swap-cycle read still sees the old bank
    always_ff @(posedge clk25) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (in_frame(bus.rd_addr)) begin
            rd_data_p1 <= mem[front_sel_q][bus.rd_addr];
        end else begin
            rd_data_p1 <= '0;
        end
    end
endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Bench for pixel_frame_buffer: frame-level reference model with per-cycle
// checks, table-driven read vectors and hand-written swap/reset sequences.
module tb_pixel_frame_buffer;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 6144;

    logic clk25;
    logic rst;

    pixel_frame_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pixel_frame_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus)
    );

    initial begin
        clk25 = 1'b0;
        forever #20 clk25 = ~clk25;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: two banks plus "frame complete, waiting for Vsync" flag
    logic [DATA_W-1:0] m_mem   [2][DEPTH];
    bit                m_known [2][DEPTH];
    bit                m_front;
    bit                m_full;
    int                m_cnt;
    bit                m_vs_prev;
    logic [DATA_W-1:0] exp_rd;
    bit                exp_rd_known;
    bit                exp_swap;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } rd_vec_t;

    rd_vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int a;
        a = int'(bus.rd_addr);
        if (rst) begin
            m_front      = 1'b0;
            m_full       = 1'b0;
            m_cnt        = 0;
            m_vs_prev    = 1'b1;
            exp_rd       = '0;
            exp_rd_known = 1'b1;
            exp_swap     = 1'b0;
            return;
        end
        if (a >= DEPTH) begin
            exp_rd       = '0;
            exp_rd_known = 1'b1;
        end else begin
            exp_rd       = m_mem[m_front][a];
            exp_rd_known = m_known[m_front][a];
        end
        exp_swap = 1'b0;
        if (!m_full) begin
            if (bus.wr_valid) begin
                m_mem[!m_front][m_cnt]   = bus.wr_data;
                m_known[!m_front][m_cnt] = 1'b1;
                if (bus.wr_last || m_cnt == DEPTH - 1) m_full = 1'b1;
                else m_cnt++;
            end
        end else if (m_vs_prev && !bus.Vsync) begin
            m_front  = !m_front;
            exp_swap = 1'b1;
            m_full   = 1'b0;
            m_cnt    = 0;
        end
        m_vs_prev = bus.Vsync;
    endfunction

    task automatic cycle();
        #5;
        chk("wr_ready", bus.wr_ready, {31'd0, !rst && !m_full});
        model_edge();
        @(posedge clk25);
        #1;
        if (exp_rd_known) chk("rd_data", bus.rd_data, exp_rd);
        chk("swap_done", bus.swap_done, exp_swap);
        chk("front_sel", bus.front_sel, m_front);
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit l,
                         input logic [ADDR_W-1:0] a, input bit vs);
        bus.wr_valid = v;
        bus.wr_data  = d;
        bus.wr_last  = l;
        bus.rd_addr  = a;
        bus.Vsync    = vs;
    endtask

    // kind 0: data = index[8:0]; 1: random; 2: constant val
    task automatic write_run(input int n, input int kind, input logic [DATA_W-1:0] val,
                             input bit last_at_end);
        for (int i = 0; i < n; i++) begin
            logic [DATA_W-1:0] d;
            case (kind)
                0:       d = DATA_W'(i);
                1:       d = DATA_W'($urandom);
                default: d = val;
            endcase
            drive(1'b1, d, last_at_end && (i == n - 1), ADDR_W'($urandom_range(0, 8191)), 1'b1);
            cycle();
        end
    endtask

    task automatic read_at(input logic [ADDR_W-1:0] a);
        drive(1'b0, '0, 1'b0, a, 1'b1);
        cycle();
    endtask

    task automatic vsync_swap();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        cycle();
        chk("swap_pulse", bus.swap_done, 1);
        cycle();
        chk("swap_single", bus.swap_done, 0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        cycle();
    endtask

    initial begin
        tbl[0] = '{addr: 13'd100,  exp: 9'd100};
        tbl[1] = '{addr: 13'd6144, exp: 9'd0};
        tbl[2] = '{addr: 13'd8191, exp: 9'd0};
        tbl[3] = '{addr: 13'd6143, exp: 9'h1FF};
        tbl[4] = '{addr: 13'd0,    exp: 9'd0};
        tbl[5] = '{addr: 13'd511,  exp: 9'h1FF};
        tbl[6] = '{addr: 13'd512,  exp: 9'd0};

        m_front   = 1'b0;
        m_full    = 1'b0;
        m_cnt     = 0;
        m_vs_prev = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) m_known[b][i] = 1'b0;

        // Reset
        rst = 1'b1;
        drive(1'b1, 9'h155, 1'b0, 13'd5, 1'b1);
        repeat (3) cycle();
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_front_sel", bus.front_sel, 0);
        chk("rst_swap_done", bus.swap_done, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        rst = 1'b0;

        // Test 1: full frame into bank 1, backpressure, swap
        write_run(DEPTH, 0, '0, 1'b0);
        chk("t1_ready_low", bus.wr_ready, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DATA_W'($urandom), 1'b0, ADDR_W'($urandom_range(0, 8191)), 1'b1);
            cycle();
        end
        chk("t1_front_hold", bus.front_sel, 0);
        vsync_swap();
        chk("t1_front_new", bus.front_sel, 1);

        // Test 2: table-driven reads of bank 1
        for (int i = 0; i < 7; i++) begin
            read_at(tbl[i].addr);
            chk($sformatf("tbl_rd[%0d]", i), bus.rd_data, tbl[i].exp);
        end

        // Fill bank 0 completely with random data, swap to it
        write_run(DEPTH, 1, '0, 1'b0);
        vsync_swap();
        chk("f2_front", bus.front_sel, 0);

        // Test 3 + 5: short frame into bank 1, then backpressure with changing data
        write_run(10, 2, 9'h0AA, 1'b1);
        chk("t3_ready_low", bus.wr_ready, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, DATA_W'($urandom), 1'b0, ADDR_W'($urandom_range(0, 8191)), 1'b1);
            cycle();
            chk("t5_ready_low", bus.wr_ready, 0);
        end
        vsync_swap();
        chk("t3_front", bus.front_sel, 1);
        for (int i = 0; i < 10; i++) begin
            read_at(ADDR_W'(i));
            chk("t3_short_px", bus.rd_data, 9'h0AA);
        end
        read_at(13'd10);
        chk("t3_stale_px", bus.rd_data, 9'd10);
        read_at(13'd11);
        chk("t3_stale_px11", bus.rd_data, 9'd11);

        // Test 4: last pixel accepted together with Vsync falling edge
        write_run(4, 1, '0, 1'b0);
        drive(1'b1, 9'h123, 1'b1, 13'd0, 1'b0);
        cycle();
        chk("t4_no_swap", bus.swap_done, 0);
        drive(1'b0, '0, 1'b0, 13'd1, 1'b0);
        repeat (3) begin
            cycle();
            chk("t4_no_swap_low", bus.swap_done, 0);
        end
        chk("t4_front_hold", bus.front_sel, 1);
        drive(1'b0, '0, 1'b0, 13'd2, 1'b1);
        cycle();
        vsync_swap();
        chk("t4_front_new", bus.front_sel, 0);
        read_at(13'd4);
        chk("t4_last_px", bus.rd_data, 9'h123);

        // Test 6: reset mid-frame
        write_run(500, 1, '0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 9'h1EE, 1'b0, 13'd100, 1'b1);
        #1;
        chk("t6_ready_in_rst", bus.wr_ready, 0);
        cycle();
        chk("t6_rd_in_rst", bus.rd_data, 0);
        cycle();
        chk("t6_rd_in_rst2", bus.rd_data, 0);
        rst = 1'b0;
        chk("t6_front_after", bus.front_sel, 0);
        drive(1'b1, 9'h111, 1'b0, '0, 1'b1); cycle();
        drive(1'b1, 9'h122, 1'b0, '0, 1'b1); cycle();
        drive(1'b1, 9'h133, 1'b1, '0, 1'b1); cycle();
        chk("t6_ready_low", bus.wr_ready, 0);
        vsync_swap();
        chk("t6_front", bus.front_sel, 1);
        read_at(13'd0); chk("t6_px0", bus.rd_data, 9'h111);
        read_at(13'd1); chk("t6_px1", bus.rd_data, 9'h122);
        read_at(13'd2); chk("t6_px2", bus.rd_data, 9'h133);

        // Randomized traffic against the model
        for (int i = 0; i < 8000; i++) begin
            rst = ($urandom_range(0, 2999) == 0);
            drive($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 63) == 0,
                  ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(6140, 8191))
                                              : ADDR_W'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 99) >= 4);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
Double-buffered pixel store that sits directly upstream of the VGA timing/colour stage and feeds its pixel_data input.
- A producer (pattern generator or image loader) streams 9-bit RGB333 pixels into the back bank through a valid/ready handshake.
- The VGA stage reads the front bank by pixel_addr with 1-cycle latency.
- The banks swap only at the start of the Vsync pulse (Vsync falling edge) after a full frame has been written, so the display never shows a partial frame.

Parameters:
ADDR_W, 13, width of read address and internal write pointer
DATA_W, 9, pixel width (RGB333: [2:0] red, [5:3] green, [8:6] blue)
DEPTH, 6144, pixels per frame per bank (96x64); must be <= 2**ADDR_W

Ports:
clk25  in  1  25 MHz pixel clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
wr_valid  in  1  producer has a pixel on wr_data
wr_data  in  DATA_W  pixel to store
wr_last  in  1  marks final pixel of a frame; qualified by the write handshake
wr_ready  out  1  buffer can accept a pixel this cycle
rd_addr  in  ADDR_W  read address, driven by the VGA stage's pixel_addr
rd_data  out  DATA_W  front-bank pixel, registered; feeds the VGA stage's pixel_data
Vsync  in  1  active-low vertical sync from the VGA stage
front_sel  out  1  bank currently displayed (0 or 1)
swap_done  out  1  one-cycle pulse on the cycle front_sel toggles

Behaviour:
- Reset values, all synchronous on rst=1:
  - state=FILL, wr_ptr=0, front_sel=0.
  - rd_data=0, swap_done=0, vs_d (registered Vsync)=1.
  - wr_ready=0 while rst=1.
  - Memory contents are not reset.
- Storage: two banks of DEPTH words each. Bank index = front_sel for reads and ~front_sel for writes.
- Write accept: wr_valid && wr_ready. Writes wr_data to back bank[wr_ptr]. wr_valid while wr_ready=0 is ignored.
- State FILL:
  - wr_ready=1.
  - On accept: wr_ptr <= wr_ptr+1.
  - If accepted with wr_last=1, or with wr_ptr==DEPTH-1, go to WAIT_SWAP. wr_ptr does not advance past DEPTH-1.
  - Vsync edges are ignored in FILL.
- State WAIT_SWAP:
  - wr_ready=0.
  - On vs_d==1 && Vsync==0: front_sel <= ~front_sel, swap_done <= 1 for one cycle, wr_ptr <= 0, go to FILL.
- Simultaneous last-pixel accept and Vsync falling edge in the same cycle: no swap that cycle; the swap waits for the next falling edge (the edge is consumed in FILL).
- Short frame (wr_last before DEPTH pixels): remaining back-bank locations keep stale data. Swap proceeds normally.
- Read path:
  - rd_data <= (rd_addr < DEPTH) ? mem[front_sel][rd_addr] : 0. Latency is exactly 1 cycle.
  - Address and bank are sampled in the same cycle.
  - rd_addr = all-ones (the VGA stage's idle value 8191) and any address >= DEPTH return 0.
- Bank switch timing: a read issued in the swap cycle uses the old front_sel. The read in the following cycle uses the new one.
- Reset mid-frame: the partial write is abandoned, front_sel returns to 0, and the next accepted pixel goes to bank 1 address 0.
- Arithmetic: wr_ptr is ADDR_W bits unsigned. Comparisons are against DEPTH-1, with no wrap.

Test Plan:
1. Reset, then feed DEPTH pixels with data = addr[8:0], wr_valid held high -> wr_ready drops the cycle after the 6144th accept; front_sel stays 0 until a Vsync 1->0 edge, then swap_done pulses once and front_sel=1; reading addr 100 gives 100 one cycle later.
2. Out-of-range reads: rd_addr=6144 and rd_addr=8191 -> rd_data=0 the next cycle; rd_addr=6143 -> stored value 6143[8:0]=0x1FF.
3. Short frame: 10 pixels of 0x0AA with wr_last on the 10th -> WAIT_SWAP after the 10th; after the swap, addresses 0-9 read 0x0AA and address 10 reads the old bank-1 content.
4. Last pixel accepted in the same cycle as the Vsync falling edge -> no swap_done; the swap occurs on the next Vsync falling edge (one frame later).
5. Backpressure: wr_valid high during WAIT_SWAP with changing wr_data -> no memory writes; after the swap, the first accepted pixel lands at address 0 of the new back bank.
6. Assert rst after 500 pixels written -> wr_ready=0 and rd_data=0 during reset, front_sel=0 after; the next frame fills bank 1 from address 0.
